// File: rtl/ldst_pkg.sv
// Shared types and default widths for the load/store memory responder.
package ldst_pkg;

    localparam int DATA_SIZE_DEF = 32;
    localparam int ADRS_SIZE_DEF = 11;
    localparam int TIMEOUT_DEF   = 64;
    localparam int N_CORES       = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_ACK   = 2'd3
    } state_t;

    typedef enum logic {
        GNT_RD = 1'b0,
        GNT_WR = 1'b1
    } gnt_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter; the pointer moves past the core whose
// grant was accepted, so that core has lowest priority on the next decision.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_i,
    input  logic       accept_i,
    output logic       gnt_valid_o,
    output logic       gnt_idx_o
);

    logic ptr_q;
    logic ptr_d;

    always_comb begin
        gnt_valid_o = |req_i;
        gnt_idx_o   = ptr_q;
        if (!req_i[ptr_q]) begin
            gnt_idx_o = ~ptr_q;
        end
        ptr_d = ptr_q;
        if (accept_i && gnt_valid_o) begin
            ptr_d = ~gnt_idx_o;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/ldst_mem_responder.sv
// Arbitrates two cores' level-held load/store requests onto one memory port.
// Optional WAIT-state timeout with per-core err flag: define LDST_TIMEOUT_EN.
//
// state    | meaning
// ST_IDLE  | no transaction; grant, address and data registered on any request
// ST_ISSUE | one-cycle mem_r_en / mem_w_en pulse
// ST_WAIT  | waiting for the matching memory completion strobe
// ST_ACK   | core valid held until the matching req is sampled low
module ldst_mem_responder
    import ldst_pkg::*;
#(
    parameter int DATA_SIZE = DATA_SIZE_DEF,
    parameter int ADRS_SIZE = ADRS_SIZE_DEF,
    parameter int TIMEOUT   = TIMEOUT_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             rd_req,
    input  logic [2*ADRS_SIZE-1:0] rd_adrs,
    input  logic [1:0]             wr_req,
    input  logic [2*ADRS_SIZE-1:0] wr_adrs,
    input  logic [2*DATA_SIZE-1:0] wr_data,
    output logic [1:0]             rd_valid,
    output logic [DATA_SIZE-1:0]   rd_data,
    output logic [1:0]             wr_valid,
    output logic [1:0]             err,
    output logic                   mem_r_en,
    output logic                   mem_w_en,
    output logic [ADRS_SIZE-1:0]   mem_r_adrs,
    output logic [ADRS_SIZE-1:0]   mem_w_adrs,
    output logic [DATA_SIZE-1:0]   mem_w_data,
    input  logic                   mem_r_valid,
    input  logic                   mem_w_valid,
    input  logic [DATA_SIZE-1:0]   mem_r_data
);

    if (TIMEOUT < 1) begin : g_timeout_range
        $error("TIMEOUT must be at least 1");
    end

    state_t                 state_q, state_d;
    gnt_t                   type_q, type_d;
    logic                   core_q, core_d;
    logic [ADRS_SIZE-1:0]   adrs_q, adrs_d;
    logic [DATA_SIZE-1:0]   wdata_q, wdata_d;
    logic [DATA_SIZE-1:0]   rd_data_q, rd_data_d;
    logic                   err_q, err_d;

    logic                   gnt_valid;
    logic                   gnt_idx;
    logic                   accept;
    logic                   timeout_hit;
    logic                   req_match;
    logic [1:0]             core_onehot;
    logic [ADRS_SIZE-1:0]   gnt_rd_adrs;
    logic [ADRS_SIZE-1:0]   gnt_wr_adrs;
    logic [DATA_SIZE-1:0]   gnt_wr_data;

    rr_arbiter2 u_arb (
        .clk         (clk),
        .rst         (rst),
        .req_i       (rd_req | wr_req),
        .accept_i    (accept),
        .gnt_valid_o (gnt_valid),
        .gnt_idx_o   (gnt_idx)
    );

    assign gnt_rd_adrs = gnt_idx ? rd_adrs[2*ADRS_SIZE-1:ADRS_SIZE] : rd_adrs[ADRS_SIZE-1:0];
    assign gnt_wr_adrs = gnt_idx ? wr_adrs[2*ADRS_SIZE-1:ADRS_SIZE] : wr_adrs[ADRS_SIZE-1:0];
    assign gnt_wr_data = gnt_idx ? wr_data[2*DATA_SIZE-1:DATA_SIZE] : wr_data[DATA_SIZE-1:0];
    assign req_match   = (type_q == GNT_RD) ? rd_req[core_q] : wr_req[core_q];

`ifdef LDST_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;

    // Loaded in ISSUE so terminal count lands on the TIMEOUT-th WAIT cycle.
    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        if (state_q == ST_ISSUE) begin
            tmo_cnt_d = TW'(TIMEOUT - 1);
        end else if (state_q == ST_WAIT && tmo_cnt_q != '0) begin
            tmo_cnt_d = tmo_cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end

    assign timeout_hit = (state_q == ST_WAIT) && (tmo_cnt_q == '0);
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        type_d    = type_q;
        core_d    = core_q;
        adrs_d    = adrs_q;
        wdata_d   = wdata_q;
        rd_data_d = rd_data_q;
        err_d     = err_q;
        accept    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (gnt_valid) begin
                    accept  = 1'b1;
                    core_d  = gnt_idx;
                    err_d   = 1'b0;
                    state_d = ST_ISSUE;
                    if (rd_req[gnt_idx]) begin
                        type_d = GNT_RD;
                        adrs_d = gnt_rd_adrs;
                    end else begin
                        type_d  = GNT_WR;
                        adrs_d  = gnt_wr_adrs;
                        wdata_d = gnt_wr_data;
                    end
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (type_q == GNT_RD && mem_r_valid) begin
                    rd_data_d = mem_r_data;
                    state_d   = ST_ACK;
                end else if (type_q == GNT_WR && mem_w_valid) begin
                    state_d = ST_ACK;
                end else if (timeout_hit) begin
                    err_d   = 1'b1;
                    state_d = ST_ACK;
                    if (type_q == GNT_RD) begin
                        rd_data_d = '0;
                    end
                end
            end
            ST_ACK: begin
                if (!req_match) begin
                    err_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            type_q    <= GNT_RD;
            core_q    <= 1'b0;
            adrs_q    <= '0;
            wdata_q   <= '0;
            rd_data_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            type_q    <= type_d;
            core_q    <= core_d;
            adrs_q    <= adrs_d;
            wdata_q   <= wdata_d;
            rd_data_q <= rd_data_d;
            err_q     <= err_d;
        end
    end

    assign core_onehot = core_q ? 2'b10 : 2'b01;

    assign mem_r_en   = (state_q == ST_ISSUE) && (type_q == GNT_RD);
    assign mem_w_en   = (state_q == ST_ISSUE) && (type_q == GNT_WR);
    assign mem_r_adrs = adrs_q;
    assign mem_w_adrs = adrs_q;
    assign mem_w_data = wdata_q;
    assign rd_data    = rd_data_q;
    assign rd_valid   = (state_q == ST_ACK && type_q == GNT_RD) ? core_onehot : 2'b00;
    assign wr_valid   = (state_q == ST_ACK && type_q == GNT_WR) ? core_onehot : 2'b00;

`ifdef LDST_TIMEOUT_EN
    assign err = (state_q == ST_ACK && err_q) ? core_onehot : 2'b00;
`else
    assign err = 2'b00;
`endif

endmodule
